// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with fixed response latency.
// Accepts one load/store per valid/ready handshake and stores data as
// little-endian 32-bit words. It returns a registered response LATENCY
// cycles after the accept edge and holds it until rsp_ready is seen.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            accept, commit, do_write;

    // Request fields captured at the accept edge
    logic [31:0]     lat_addr, lat_wdata;
    logic [1:0]      lat_size;
    logic            lat_we, lat_signed;

    // Fields of the transaction being decoded (live inputs while IDLE so a
    // LATENCY=1 commit on the accept edge sees the request directly)
    logic [31:0]     cur_addr, cur_wdata;
    logic [1:0]      cur_size;
    logic            cur_we, cur_signed;

    logic [31:0]     off;
    logic [1:0]      lane;
    logic [AW-1:0]   idx;
    logic            in_range, size_bad, misalign, dec_err;
    logic [31:0]     word_q, load_data, wr_data;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [3:0]      wr_mask;

    logic [31:0]     mem [DEPTH_WORDS];

    assign req_ready = (state == S_IDLE) && !reset;

    assign cur_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
    assign cur_we     = (state == S_IDLE) ? req_we     : lat_we;
    assign cur_size   = (state == S_IDLE) ? req_size   : lat_size;
    assign cur_signed = (state == S_IDLE) ? req_signed : lat_signed;
    assign cur_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;

    // Address decode: range, alignment and size legality
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        size_bad = 1'b0;
        misalign = 1'b0;
        off      = cur_addr - BASE_ADDR;
        lane     = off[1:0];
        idx      = off[AW+1:2];
        in_range = (off < SPAN);
        case (cur_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lane[0];
            2'b10:   misalign = (lane != 2'b00);
            default: size_bad = 1'b1;
        endcase
        dec_err = size_bad | misalign | ~in_range;
    end

    // Load lane extraction/extension and store lane mask/data replication
    always_comb begin
        word_q    = mem[idx];
        byte_sel  = word_q[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? word_q[31:16] : word_q[15:0];
        load_data = 32'h0;
        wr_mask   = 4'b0000;
        wr_data   = cur_wdata;
        case (cur_size)
            2'b00: begin
                load_data = {{24{cur_signed & byte_sel[7]}}, byte_sel};
                wr_mask   = 4'b0001 << lane;
                wr_data   = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                load_data = {{16{cur_signed & half_sel[15]}}, half_sel};
                wr_mask   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                load_data = word_q;
                wr_mask   = 4'b1111;
            end
            default: ;
        endcase
    end

    // Next-state logic: accept in IDLE, count down in WAIT, drain in RESP
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        commit     = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = CW'(LATENCY - 1);
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign do_write = commit & cur_we & ~dec_err & ~reset;

    // State register and registered response; reset drops any transaction
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= dec_err;
                rsp_rdata <= (cur_we || dec_err) ? 32'h0 : load_data;
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Capture the request on the accept edge
    always_ff @(posedge clock) begin
        if (accept && !reset) begin
            lat_addr   <= req_addr;
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_wdata  <= req_wdata;
        end
    end

    // Storage write on the commit edge, selected byte lanes only
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset; contents survive reset and only the control path is cleared.
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Drives inputs on the falling edge and samples outputs there too.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    dmem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    // One full transaction; lat counts edges from accept to rsp_valid (bounded)
    task automatic run_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat);
        @(negedge clock);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        rsp_ready  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_word();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{32'h0100_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, "store_word"});
        v.push_back('{32'h0100_0010, 1'b0, 2'b10, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, "load_word"});
        foreach (v[i]) begin
            run_req(v[i].addr, v[i].we, v[i].size, v[i].sgn, v[i].wdata, rd, er, lat);
            total++; if (rd !== v[i].exp_rd) begin bad++; $display("FAIL %s rdata got=%h want=%h", v[i].name, rd, v[i].exp_rd); end
            total++; if (er !== v[i].exp_err) begin bad++; $display("FAIL %s err got=%b want=%b", v[i].name, er, v[i].exp_err); end
            total++; if (lat !== 2) begin bad++; $display("FAIL %s latency got=%0d want=2", v[i].name, lat); end
        end
    endtask

    task automatic test_subword_load();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{32'h0100_0013, 1'b0, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFDE, 1'b0, "byte_signed"});
        v.push_back('{32'h0100_0013, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_00DE, 1'b0, "byte_unsigned"});
        v.push_back('{32'h0100_0012, 1'b0, 2'b01, 1'b1, 32'h0, 32'hFFFF_DEAD, 1'b0, "half_signed_hi"});
        v.push_back('{32'h0100_0010, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0, "half_unsigned_lo"});
        v.push_back('{32'h0100_0011, 1'b0, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFBE, 1'b0, "byte_signed_lane1"});
        foreach (v[i]) begin
            run_req(v[i].addr, v[i].we, v[i].size, v[i].sgn, v[i].wdata, rd, er, lat);
            total++; if (rd !== v[i].exp_rd) begin bad++; $display("FAIL %s rdata got=%h want=%h", v[i].name, rd, v[i].exp_rd); end
            total++; if (er !== v[i].exp_err) begin bad++; $display("FAIL %s err got=%b want=%b", v[i].name, er, v[i].exp_err); end
        end
    endtask

    task automatic test_lane_store();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{32'h0100_0011, 1'b1, 2'b00, 1'b0, 32'hAAAA_AA55, 32'h0, 1'b0, "store_byte"});
        v.push_back('{32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0, "load_after_byte"});
        v.push_back('{32'h0100_0014, 1'b1, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 1'b0, "store_word14"});
        v.push_back('{32'h0100_0016, 1'b1, 2'b01, 1'b0, 32'h9999_ABCD, 32'h0, 1'b0, "store_half_hi"});
        v.push_back('{32'h0100_0014, 1'b0, 2'b10, 1'b0, 32'h0, 32'hABCD_3344, 1'b0, "load_after_half"});
        v.push_back('{32'h0100_0FFC, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, "store_last_word"});
        v.push_back('{32'h0100_0FFF, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_00CA, 1'b0, "load_last_byte"});
        foreach (v[i]) begin
            run_req(v[i].addr, v[i].we, v[i].size, v[i].sgn, v[i].wdata, rd, er, lat);
            total++; if (rd !== v[i].exp_rd) begin bad++; $display("FAIL %s rdata got=%h want=%h", v[i].name, rd, v[i].exp_rd); end
            total++; if (er !== v[i].exp_err) begin bad++; $display("FAIL %s err got=%b want=%b", v[i].name, er, v[i].exp_err); end
        end
    endtask

    task automatic test_errors();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat;
        v.push_back('{32'h0100_0011, 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, "half_misaligned_store"});
        v.push_back('{32'h0100_0012, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, "word_misaligned_store"});
        v.push_back('{32'h0100_0010, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, "size11_store"});
        v.push_back('{32'h0100_0011, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1, "half_misaligned_load"});
        v.push_back('{32'h0100_1000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, "above_range"});
        v.push_back('{32'h00FF_FFFC, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, "below_base"});
        v.push_back('{32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0, "unchanged_after_err"});
        foreach (v[i]) begin
            run_req(v[i].addr, v[i].we, v[i].size, v[i].sgn, v[i].wdata, rd, er, lat);
            total++; if (rd !== v[i].exp_rd) begin bad++; $display("FAIL %s rdata got=%h want=%h", v[i].name, rd, v[i].exp_rd); end
            total++; if (er !== v[i].exp_err) begin bad++; $display("FAIL %s err got=%b want=%b", v[i].name, er, v[i].exp_err); end
            total++; if (lat !== 2) begin bad++; $display("FAIL %s latency got=%0d want=2", v[i].name, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er;
        int lat;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h0100_0010; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clock); lat++; end
        total++; if (lat !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", lat); end
        // Hold the response and offer a conflicting store that must be ignored
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_addr = 32'h0100_0010; req_size = 2'b10;
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, rsp_valid); end
            total++; if (rsp_rdata !== 32'hDEAD_55EF) begin bad++; $display("FAIL bp_hold_rdata[%0d] got=%h want=deaD55ef", i, rsp_rdata); end
            total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL bp_hold_err[%0d] got=%b want=0", i, rsp_err); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_req_ready[%0d] got=%b want=0", i, req_ready); end
            @(negedge clock);
        end
        req_valid = 1'b0; req_we = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_req_ready got=%b want=1", req_ready); end
        run_req(32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_55EF) begin bad++; $display("FAIL bp_ignored_store got=%h want=dead55ef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h0100_0010; req_we = 1'b1; req_size = 2'b10; req_wdata = 32'h1234_5678;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_we = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_wait_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_wait_err got=%b want=0", rsp_err); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_wait_req_ready got=%b want=0", req_ready); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_after_valid got=%b want=0", rsp_valid); end
        run_req(32'h0100_0010, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEAD_55EF) begin bad++; $display("FAIL rst_store_dropped got=%h want=dead55ef", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL rst_recover_latency got=%0d want=2", lat); end
    endtask

    task automatic test_reset_resp_edge();
        int lat;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h0100_0014; req_we = 1'b0; req_size = 2'b10;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clock); lat++; end
        total++; if (rsp_rdata !== 32'hABCD_3344) begin bad++; $display("FAIL rr_pre_rdata got=%h want=abcd3344", rsp_rdata); end
        rsp_ready = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rr_rdata got=%h want=0", rsp_rdata); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rr_req_ready got=%b want=0", req_ready); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rr_recover_req_ready got=%b want=1", req_ready); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_lane_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_reset_resp_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
